mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter SB_DEPTH, default 4, store-buffer entry count (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have fetch ports: fetch_addr in 32, fetch_addr_en in 1 (request held until answered), fetch_inst out 32, fetch_inst_valid out 1, fetch_access_fault out 1.
REQ-005 SHALL have load ports: load_addr in 32, load_addr_valid in 1 (held until answered), load_size in 2, load_data out 32, load_data_valid out 1, load_access_fault out 1.
REQ-006 SHALL have store ports: store_addr in 32, store_val in 32, store_size in 2, store_valid in 1 (push strobe), store_full out 1, store_fault out 1.
REQ-007 SHALL have memory ports: mem_addr out 32, mem_wdata out 32, mem_size out 2, mem_we out 1, mem_req out 1, mem_ready in 1, mem_rdata in 32, mem_rvalid in 1, mem_fault in 1.

Function
REQ-008 Size encoding SHALL be 00 byte, 01 half, 10 word; fetches SHALL always issue size 10.
REQ-009 Store buffer SHALL be a SB_DEPTH-entry FIFO; store_valid with store_full low pushes {addr,val,size}; push while store_full high SHALL be ignored.
REQ-010 store_full SHALL equal (count==SB_DEPTH) from registered count; simultaneous push and pop when full SHALL reject the push, pop proceeds.
REQ-011 FSM SHALL have states IDLE, REQ, RESP; exactly one memory transaction outstanding.
REQ-012 IDLE: when any requester pending, SHALL latch winner's addr/data/size/we and go to REQ next cycle.
REQ-013 Priority SHALL be store-buffer-nonempty > load > fetch, except: after a store or load grant, a pending fetch SHALL win the next grant.
REQ-014 Load SHALL NOT be granted while store buffer nonempty (load-after-store ordering).
REQ-015 REQ: mem_req high with stable mem_addr/mem_wdata/mem_size/mem_we; on mem_ready high go to RESP.
REQ-016 RESP: on mem_rvalid go to IDLE; writes also complete on mem_rvalid (write ack); store entry popped at that edge.
REQ-017 Read response SHALL be registered: fetch/load valid or fault pulses one cycle, cycle after mem_rvalid, with mem_rdata in fetch_inst/load_data.
REQ-018 mem_fault with mem_rvalid SHALL pulse the access_fault output instead of valid (valid stays 0); store fault pulses store_fault.
REQ-019 Response SHALL be discarded (no pulse) if requester's en/valid is low or its addr differs from latched addr at mem_rvalid (flush/redirect); FSM still returns to IDLE.
REQ-020 Minimum request-to-response latency SHALL be 3 cycles (IDLE grant, REQ with mem_ready=1, RESP with mem_rvalid=1, pulse next).
REQ-021 A requester whose response pulse is in flight SHALL NOT be re-granted in that same cycle's IDLE decision.
REQ-022 mem_req SHALL be low outside REQ; mem_we SHALL be high only for store transactions.

Reset
REQ-023 reset low SHALL asynchronously force IDLE, store buffer empty (store_full 0), fairness flag cleared, all outputs 0.
REQ-024 Reset mid-transaction SHALL abandon it; no response pulse after reset release.

Verification
REQ-025 Fetch 0x100, mem_ready=1, mem_rvalid=1 next, rdata 0x00000013 -> mem_req one cycle, size 10, fetch_inst_valid pulse with 0x00000013 on cycle 4.
REQ-026 Push 4 stores with SB_DEPTH=4 -> store_full 1; 5th push ignored; four writes drain in push order; store_full 0 after first ack.
REQ-027 Store pending, load 0x200 and fetch held -> order store, fetch, load; load not issued before store ack.
REQ-028 Fetch 0x100 outstanding, fetch_addr changes to 0x400 before mem_rvalid -> first response dropped, new fetch to 0x400 issued and answered.
REQ-029 Load with mem_fault=1 on response -> load_access_fault pulse, load_data_valid stays 0; FSM in IDLE next cycle.
REQ-030 Assert reset low while in RESP -> outputs 0 immediately; late mem_rvalid after release produces no pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: a store buffer, a load port and a fetch port share one
// memory interface with exactly one transaction outstanding at a time.
module mem_arbiter #(
  parameter int unsigned SB_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] fetch_addr,
  input  logic        fetch_addr_en,
  output logic [31:0] fetch_inst,
  output logic        fetch_inst_valid,
  output logic        fetch_access_fault,
  input  logic [31:0] load_addr,
  input  logic        load_addr_valid,
  input  logic [1:0]  load_size,
  output logic [31:0] load_data,
  output logic        load_data_valid,
  output logic        load_access_fault,
  input  logic [31:0] store_addr,
  input  logic [31:0] store_val,
  input  logic [1:0]  store_size,
  input  logic        store_valid,
  output logic        store_full,
  output logic        store_fault,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_size,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  input  logic        mem_fault
);

  localparam int unsigned PtrW = $clog2(SB_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;
  typedef enum logic [1:0] {GntNone, GntFetch, GntLoad, GntStore} gnt_e;

  state_e r_state;
  gnt_e   r_gnt;
  gnt_e   w_gnt;
  logic   r_fetch_pri;

  logic [31:0]     r_sb_addr [SB_DEPTH];
  logic [31:0]     r_sb_val  [SB_DEPTH];
  logic [1:0]      r_sb_size [SB_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;

  logic w_push, w_pop, w_sb_ne, w_fetch_ok, w_load_ok;

  assign store_full = (r_count == CntW'(SB_DEPTH));
  assign w_sb_ne    = (r_count != '0);
  assign w_push     = store_valid && !store_full;
  assign w_pop      = (r_state == StResp) && mem_rvalid && (r_gnt == GntStore);

  // A requester whose response is being pulsed this cycle must not be granted again.
  assign w_fetch_ok = fetch_addr_en && !(fetch_inst_valid || fetch_access_fault);
  assign w_load_ok  = load_addr_valid && !(load_data_valid || load_access_fault) && !w_sb_ne;

  always_comb begin
    w_gnt = GntNone;
    if (r_fetch_pri && w_fetch_ok) w_gnt = GntFetch;
    else if (w_sb_ne)              w_gnt = GntStore;
    else if (w_load_ok)            w_gnt = GntLoad;
    else if (w_fetch_ok)           w_gnt = GntFetch;
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_sb_addr[r_wr_ptr] <= store_addr;
      r_sb_val[r_wr_ptr]  <= store_val;
      r_sb_size[r_wr_ptr] <= store_size;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PtrW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PtrW'(1);
      r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state            <= StIdle;
      r_gnt              <= GntNone;
      r_fetch_pri        <= 1'b0;
      mem_addr           <= '0;
      mem_wdata          <= '0;
      mem_size           <= '0;
      mem_we             <= 1'b0;
      mem_req            <= 1'b0;
      fetch_inst         <= '0;
      fetch_inst_valid   <= 1'b0;
      fetch_access_fault <= 1'b0;
      load_data          <= '0;
      load_data_valid    <= 1'b0;
      load_access_fault  <= 1'b0;
      store_fault        <= 1'b0;
    end else begin
      fetch_inst_valid   <= 1'b0;
      fetch_access_fault <= 1'b0;
      load_data_valid    <= 1'b0;
      load_access_fault  <= 1'b0;
      store_fault        <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_gnt != GntNone) begin
            r_gnt       <= w_gnt;
            r_state     <= StReq;
            mem_req     <= 1'b1;
            r_fetch_pri <= (w_gnt != GntFetch);
            case (w_gnt)
              GntStore: begin
                mem_addr  <= r_sb_addr[r_rd_ptr];
                mem_wdata <= r_sb_val[r_rd_ptr];
                mem_size  <= r_sb_size[r_rd_ptr];
                mem_we    <= 1'b1;
              end
              GntLoad: begin
                mem_addr  <= load_addr;
                mem_wdata <= '0;
                mem_size  <= load_size;
                mem_we    <= 1'b0;
              end
              default: begin
                mem_addr  <= fetch_addr;
                mem_wdata <= '0;
                mem_size  <= 2'b10;
                mem_we    <= 1'b0;
              end
            endcase
          end
        end
        StReq: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            r_state <= StResp;
          end
        end
        StResp: begin
          if (mem_rvalid) begin
            r_state <= StIdle;
            mem_we  <= 1'b0;
            // Responses to a withdrawn or redirected request are dropped silently.
            case (r_gnt)
              GntFetch: begin
                if (fetch_addr_en && fetch_addr == mem_addr) begin
                  fetch_inst_valid   <= !mem_fault;
                  fetch_access_fault <= mem_fault;
                  if (!mem_fault) fetch_inst <= mem_rdata;
                end
              end
              GntLoad: begin
                if (load_addr_valid && load_addr == mem_addr) begin
                  load_data_valid   <= !mem_fault;
                  load_access_fault <= mem_fault;
                  if (!mem_fault) load_data <= mem_rdata;
                end
              end
              GntStore: store_fault <= mem_fault;
              default:  ;
            endcase
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small memory responder that logs every
// accepted transaction.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] fetch_addr, fetch_inst;
  logic        fetch_addr_en, fetch_inst_valid, fetch_access_fault;
  logic [31:0] load_addr, load_data;
  logic        load_addr_valid, load_data_valid, load_access_fault;
  logic [1:0]  load_size;
  logic [31:0] store_addr, store_val;
  logic [1:0]  store_size;
  logic        store_valid, store_full, store_fault;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        mem_we, mem_req, mem_ready, mem_rvalid, mem_fault;

  always #5 clk = ~clk;

  mem_arbiter #(.SB_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset),
    .fetch_addr(fetch_addr), .fetch_addr_en(fetch_addr_en), .fetch_inst(fetch_inst),
    .fetch_inst_valid(fetch_inst_valid), .fetch_access_fault(fetch_access_fault),
    .load_addr(load_addr), .load_addr_valid(load_addr_valid), .load_size(load_size),
    .load_data(load_data), .load_data_valid(load_data_valid),
    .load_access_fault(load_access_fault),
    .store_addr(store_addr), .store_val(store_val), .store_size(store_size),
    .store_valid(store_valid), .store_full(store_full), .store_fault(store_fault),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_we(mem_we),
    .mem_req(mem_req), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .mem_rvalid(mem_rvalid), .mem_fault(mem_fault)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h0000_0013;
    return {a[15:0], 16'hBEEF};
  endfunction

  // Responder / monitor: runs at +2 after each edge, after the test has driven inputs.
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];
  logic [1:0]  log_size[$];
  logic        log_we[$];
  int          delay = 0;
  logic [31:0] fault_addr = 32'hFFFF_FFFF;
  int          rsp_cnt = 0;
  logic [31:0] rsp_addr;
  logic        rsp_we;
  int          n_fetch = 0, n_req = 0, n_wack = 0;

  initial begin
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    mem_fault  = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      mem_rvalid = 1'b0;
      mem_fault  = 1'b0;
      if (fetch_inst_valid) n_fetch++;
      if (mem_req) n_req++;
      if (rsp_cnt != 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_fn(rsp_addr);
          mem_fault  = (rsp_addr == fault_addr);
          if (rsp_we) n_wack++;
        end
      end
      if (mem_req && mem_ready) begin
        log_addr.push_back(mem_addr);
        log_wdata.push_back(mem_wdata);
        log_size.push_back(mem_size);
        log_we.push_back(mem_we);
        rsp_addr = mem_addr;
        rsp_we   = mem_we;
        rsp_cnt  = delay + 1;
      end
    end
  end

  task automatic clear_log();
    log_addr.delete();
    log_wdata.delete();
    log_size.delete();
    log_we.delete();
  endtask

  task automatic do_fetch(input logic [31:0] a, output int lat, output logic [31:0] d);
    fetch_addr    = a;
    fetch_addr_en = 1'b1;
    lat = 0;
    while (!fetch_inst_valid && lat < 20) begin
      step();
      lat++;
    end
    d = fetch_inst;
    fetch_addr_en = 1'b0;
  endtask

  int          lat, k, base, base2;
  logic [31:0] got_f, got_l;

  initial begin
    reset = 1'b0;
    fetch_addr = '0; fetch_addr_en = 1'b0;
    load_addr = '0; load_addr_valid = 1'b0; load_size = '0;
    store_addr = '0; store_val = '0; store_size = '0; store_valid = 1'b0;
    mem_ready = 1'b1;
    step(2);
    check_eq("rst_mem_req", mem_req, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_store_full", store_full, 0);
    check_eq("rst_fetch_valid", fetch_inst_valid, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    reset = 1'b1;
    step();

    // Basic fetch, minimum latency
    clear_log();
    base = n_req;
    do_fetch(32'h100, lat, got_f);
    check_eq("fetch_latency", lat, 3);
    check_eq("fetch_inst", got_f, 32'h0000_0013);
    check_eq("fetch_req_cycles", n_req - base, 1);
    check_eq("fetch_size", log_size[0], 2'b10);
    check_eq("fetch_we", log_we[0], 0);
    check_eq("fetch_addr", log_addr[0], 32'h100);
    step();
    check_eq("fetch_pulse_width", fetch_inst_valid, 0);
    step(3);
    check_eq("fetch_no_regrant", log_addr.size(), 1);

    // Fill store buffer while memory stalls, then drain
    clear_log();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) check_eq("sb_full", store_full, 1);
      store_addr  = 32'h1000 + 32'(i * 4);
      store_val   = 32'hC0DE_0000 + 32'(i);
      store_size  = 2'(i % 3);
      store_valid = 1'b1;
      step();
    end
    store_valid = 1'b0;
    check_eq("sb_full_after_extra", store_full, 1);
    base = n_wack;
    mem_ready = 1'b1;
    lat = 0;
    while (store_full && lat < 20) begin
      step();
      lat++;
    end
    check_eq("sb_full_clear", store_full, 0);
    check_eq("sb_clear_after_first_ack", n_wack - base, 1);
    step(20);
    check_eq("sb_drain_count", log_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq("sb_drain_addr", log_addr[i], 32'h1000 + 32'(i * 4));
      check_eq("sb_drain_wdata", log_wdata[i], 32'hC0DE_0000 + 32'(i));
      check_eq("sb_drain_size", log_size[i], 32'(i % 3));
      check_eq("sb_drain_we", log_we[i], 1);
    end

    // Store pending with load and fetch held: store, fetch, load
    clear_log();
    mem_ready = 1'b0;
    store_addr = 32'h300; store_val = 32'h55AA_55AA; store_size = 2'b10; store_valid = 1'b1;
    step();
    store_valid = 1'b0;
    step();
    load_addr = 32'h200; load_size = 2'b01; load_addr_valid = 1'b1;
    fetch_addr = 32'h500; fetch_addr_en = 1'b1;
    step();
    mem_ready = 1'b1;
    k = 0;
    got_f = '0;
    got_l = '0;
    while ((fetch_addr_en || load_addr_valid) && k < 40) begin
      step();
      k++;
      if (fetch_inst_valid) begin
        got_f = fetch_inst;
        fetch_addr_en = 1'b0;
      end
      if (load_data_valid) begin
        got_l = load_data;
        load_addr_valid = 1'b0;
      end
    end
    check_eq("order_done", {31'b0, fetch_addr_en | load_addr_valid}, 0);
    check_eq("order_count", log_addr.size(), 3);
    check_eq("order0_addr", log_addr[0], 32'h300);
    check_eq("order0_we", log_we[0], 1);
    check_eq("order0_wdata", log_wdata[0], 32'h55AA_55AA);
    check_eq("order1_addr", log_addr[1], 32'h500);
    check_eq("order2_addr", log_addr[2], 32'h200);
    check_eq("order2_size", log_size[2], 2'b01);
    check_eq("order_fetch_data", got_f, 32'h0500_BEEF);
    check_eq("order_load_data", got_l, 32'h0200_BEEF);

    // Redirect while outstanding: first response dropped
    step(2);
    clear_log();
    delay = 2;
    base = n_fetch;
    fetch_addr = 32'h100; fetch_addr_en = 1'b1;
    k = 0;
    while (log_addr.size() == 0 && k < 20) begin
      step();
      k++;
    end
    fetch_addr = 32'h400;
    k = 0;
    while (!fetch_inst_valid && k < 30) begin
      step();
      k++;
    end
    check_eq("redirect_data", fetch_inst, 32'h0400_BEEF);
    fetch_addr_en = 1'b0;
    step(2);
    check_eq("redirect_pulses", n_fetch - base, 1);
    check_eq("redirect_count", log_addr.size(), 2);
    check_eq("redirect_addr", log_addr[1], 32'h400);
    delay = 0;

    // Load fault and store fault
    fault_addr = 32'h600;
    load_addr = 32'h600; load_size = 2'b01; load_addr_valid = 1'b1;
    k = 0;
    while (!(load_access_fault || load_data_valid) && k < 20) begin
      step();
      k++;
    end
    check_eq("lfault_pulse", load_access_fault, 1);
    check_eq("lfault_valid", load_data_valid, 0);
    load_addr_valid = 1'b0;
    step();
    check_eq("lfault_width", load_access_fault, 0);
    check_eq("lfault_idle_req", mem_req, 0);
    do_fetch(32'h800, lat, got_f);
    check_eq("post_fault_latency", lat, 3);
    check_eq("post_fault_data", got_f, 32'h0800_BEEF);
    store_addr = 32'h600; store_val = 32'h1; store_size = 2'b10; store_valid = 1'b1;
    step();
    store_valid = 1'b0;
    k = 0;
    while (!store_fault && k < 20) begin
      step();
      k++;
    end
    check_eq("sfault_pulse", store_fault, 1);
    step();
    check_eq("sfault_width", store_fault, 0);
    fault_addr = 32'hFFFF_FFFF;

    // Reset during RESP; late rvalid must be ignored
    step(2);
    clear_log();
    delay = 3;
    fetch_addr = 32'h700; fetch_addr_en = 1'b1;
    k = 0;
    while (log_addr.size() == 0 && k < 20) begin
      step();
      k++;
    end
    reset = 1'b0;
    fetch_addr_en = 1'b0;
    #1;
    check_eq("rresp_mem_req", mem_req, 0);
    check_eq("rresp_mem_addr", mem_addr, 0);
    check_eq("rresp_fetch_valid", fetch_inst_valid, 0);
    step();
    reset = 1'b1;
    base = n_fetch;
    step(6);
    check_eq("rresp_no_pulse", n_fetch - base, 0);
    check_eq("rresp_no_new_req", log_addr.size(), 1);
    delay = 0;

    // Reset during REQ of a store empties the buffer
    mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      store_addr = 32'h900 + 32'(i * 4); store_val = 32'(i); store_valid = 1'b1;
      step();
    end
    store_valid = 1'b0;
    step(2);
    check_eq("rreq_pre_req", mem_req, 1);
    check_eq("rreq_pre_we", mem_we, 1);
    reset = 1'b0;
    #1;
    check_eq("rreq_mem_req", mem_req, 0);
    check_eq("rreq_mem_we", mem_we, 0);
    step();
    reset = 1'b1;
    mem_ready = 1'b1;
    base2 = log_addr.size();
    step(8);
    check_eq("rreq_sb_flushed", log_addr.size(), base2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
